// File: rtl/mips_core_pkg.sv
// Shared core types and constants, plus the data-cache FSM state and line metadata.
package mips_core_pkg;

  localparam int ADDR_WIDTH     = 32;
  localparam int DATA_WIDTH     = 32;
  localparam int ROB_DEPTH_BITS = 4;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } MemAccessType;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_FILL_REQ  = 2'd1,
    S_FILL      = 2'd2,
    S_STORE_REQ = 2'd3
  } dcache_state_e;

  // The tag field is address-wide so cache geometry stays a parameter of the
  // cache itself; bits above the real tag are always written as zero.
  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] tag;
  } dcache_line_meta;

endpackage

// File: rtl/dcache_data_array.sv
// Data storage for the direct-mapped cache: one write port with a per-word
// enable and one combinational read port, both addressed by {index, offset}.
module dcache_data_array #(
  parameter int INDEX_BITS = 4,
  parameter int OFF_BITS   = 2,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [INDEX_BITS-1:0] i_wr_index,
  input  logic [OFF_BITS-1:0]   i_wr_offset,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [INDEX_BITS-1:0] i_rd_index,
  input  logic [OFF_BITS-1:0]   i_rd_offset,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int DEPTH = 1 << (INDEX_BITS + OFF_BITS);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Single-word write; contents need no reset because line valid bits gate use.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[{i_wr_index, i_wr_offset}] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[{i_rd_index, i_rd_offset}];

endmodule

// File: rtl/d_cache_responder.sv
// Memory-side responder: direct-mapped write-through, no-write-allocate data
// cache servicing loads (hit or line refill) and committed stores.
module d_cache_responder
  import mips_core_pkg::*;
#(
  parameter int INDEX_BITS = 4,
  parameter int LINE_WORDS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  input  MemAccessType              req_action,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [ROB_DEPTH_BITS-1:0] req_tag,
  input  logic [DATA_WIDTH-1:0]     req_data,
  input  logic                      flush,
  output logic                      stall,
  output logic                      rsp_valid,
  output logic [ROB_DEPTH_BITS-1:0] rsp_tag,
  output logic [DATA_WIDTH-1:0]     rsp_data,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic                      mem_req_we,
  output logic [ADDR_WIDTH-1:0]     mem_req_addr,
  output logic [DATA_WIDTH-1:0]     mem_req_wdata,
  input  logic                      mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]     mem_rsp_data
);

  localparam int OFF_BITS = $clog2(LINE_WORDS);
  localparam int SETS     = 1 << INDEX_BITS;
  localparam int TAG_LSB  = 2 + OFF_BITS + INDEX_BITS;
  localparam logic [OFF_BITS-1:0] LAST_BEAT = OFF_BITS'(LINE_WORDS - 1);

  dcache_state_e              r_state, w_next_state;
  dcache_line_meta            r_meta [SETS];
  logic [ADDR_WIDTH-1:2]      r_waddr;
  logic [ROB_DEPTH_BITS-1:0]  r_rob_tag;
  logic                       r_pend;
  logic [OFF_BITS-1:0]        r_beat;
  logic [ADDR_WIDTH-1:0]      r_mem_addr;
  logic [DATA_WIDTH-1:0]      r_mem_wdata;
  logic                       r_rsp_valid;
  logic [ROB_DEPTH_BITS-1:0]  r_rsp_tag;
  logic [DATA_WIDTH-1:0]      r_rsp_data;

  logic [OFF_BITS-1:0]          w_offset, w_l_offset, w_rd_offset, w_wr_offset;
  logic [INDEX_BITS-1:0]        w_index, w_l_index, w_rd_index, w_wr_index;
  logic [ADDR_WIDTH-TAG_LSB-1:0] w_tag, w_l_tag;
  logic                         w_hit, w_is_write, w_last_beat, w_load_hit, w_accept_stall;
  logic                         w_stall, w_mem_req_valid, w_mem_req_we, w_arr_we;
  logic [DATA_WIDTH-1:0]        w_arr_wdata, w_rd_data, w_fill_word;

  // Incoming request fields and fields of the latched (in-progress) request.
  assign w_offset    = req_addr[2 +: OFF_BITS];
  assign w_index     = req_addr[2 + OFF_BITS +: INDEX_BITS];
  assign w_tag       = req_addr[ADDR_WIDTH-1:TAG_LSB];
  assign w_l_offset  = r_waddr[2 +: OFF_BITS];
  assign w_l_index   = r_waddr[2 + OFF_BITS +: INDEX_BITS];
  assign w_l_tag     = r_waddr[ADDR_WIDTH-1:TAG_LSB];

  assign w_is_write  = (req_action == WRITE);
  assign w_hit       = r_meta[w_index].valid && (r_meta[w_index].tag == ADDR_WIDTH'(w_tag));
  assign w_last_beat = (r_state == S_FILL) && mem_rsp_valid && (r_beat == LAST_BEAT);
  assign w_load_hit  = (r_state == S_IDLE) && req_valid && !w_is_write && w_hit;
  assign w_accept_stall = (r_state == S_IDLE) && req_valid && w_stall;
  // The requested word is the beat arriving now only when it sits at the last offset.
  assign w_fill_word = (w_l_offset == LAST_BEAT) ? mem_rsp_data : w_rd_data;

  dcache_data_array #(
    .INDEX_BITS (INDEX_BITS),
    .OFF_BITS   (OFF_BITS),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_data (
    .clk         (clk),
    .i_we        (w_arr_we),
    .i_wr_index  (w_wr_index),
    .i_wr_offset (w_wr_offset),
    .i_wdata     (w_arr_wdata),
    .i_rd_index  (w_rd_index),
    .i_rd_offset (w_rd_offset),
    .o_rdata     (w_rd_data)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid && w_is_write) begin
          w_next_state = S_STORE_REQ;
        end else if (req_valid && !w_hit) begin
          w_next_state = S_FILL_REQ;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_FILL_REQ: begin
        if (mem_req_ready) w_next_state = S_FILL;
        else               w_next_state = S_FILL_REQ;
      end
      S_FILL: begin
        if (w_last_beat) w_next_state = S_IDLE;
        else             w_next_state = S_FILL;
      end
      S_STORE_REQ: begin
        if (mem_req_ready) w_next_state = S_IDLE;
        else               w_next_state = S_STORE_REQ;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // FSM outputs: back-pressure, memory request strobes and data-array ports.
  always_comb begin
    w_stall         = 1'b0;
    w_mem_req_valid = 1'b0;
    w_mem_req_we    = 1'b0;
    w_arr_we        = 1'b0;
    w_wr_index      = w_l_index;
    w_wr_offset     = r_beat;
    w_arr_wdata     = mem_rsp_data;
    w_rd_index      = w_l_index;
    w_rd_offset     = w_l_offset;
    case (r_state)
      S_IDLE: begin
        w_stall     = req_valid && (w_is_write || !w_hit);
        // Store hit updates the cached copy; a store miss does not allocate.
        w_arr_we    = req_valid && w_is_write && w_hit;
        w_wr_index  = w_index;
        w_wr_offset = w_offset;
        w_arr_wdata = req_data;
        w_rd_index  = w_index;
        w_rd_offset = w_offset;
      end
      S_FILL_REQ: begin
        w_stall         = 1'b1;
        w_mem_req_valid = 1'b1;
      end
      S_FILL: begin
        w_stall  = !w_last_beat;
        w_arr_we = mem_rsp_valid;
      end
      S_STORE_REQ: begin
        w_stall         = !mem_req_ready;
        w_mem_req_valid = 1'b1;
        w_mem_req_we    = 1'b1;
      end
      default: begin
        w_stall = 1'b0;
      end
    endcase
  end

  // Latch the stalled request and build the memory request payload, held until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_waddr     <= '0;
      r_rob_tag   <= '0;
      r_pend      <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else if (w_accept_stall) begin
      r_waddr     <= req_addr[ADDR_WIDTH-1:2];
      r_rob_tag   <= req_tag;
      r_pend      <= !w_is_write && !flush;
      r_mem_addr  <= w_is_write ? (req_addr & ~ADDR_WIDTH'(3))
                                : (req_addr & ~ADDR_WIDTH'(LINE_WORDS * 4 - 1));
      r_mem_wdata <= w_is_write ? req_data : r_mem_wdata;
    end else if (flush && (r_state == S_FILL_REQ || r_state == S_FILL)) begin
      r_pend      <= 1'b0;
    end
  end

  // Refill beat counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat <= '0;
    end else if (r_state == S_FILL_REQ && mem_req_ready) begin
      r_beat <= '0;
    end else if (r_state == S_FILL && mem_rsp_valid) begin
      r_beat <= r_beat + OFF_BITS'(1);
    end
  end

  // Line metadata: cleared on reset, installed after the final refill beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SETS; i++) begin
        r_meta[i] <= '0;
      end
    end else if (w_last_beat) begin
      r_meta[w_l_index] <= '{valid: 1'b1, tag: ADDR_WIDTH'(w_l_tag)};
    end
  end

  // Load result register; a flush suppresses any result not yet issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_tag   <= '0;
      r_rsp_data  <= '0;
    end else if (w_load_hit) begin
      r_rsp_valid <= !flush;
      r_rsp_tag   <= req_tag;
      r_rsp_data  <= w_rd_data;
    end else if (w_last_beat) begin
      r_rsp_valid <= r_pend && !flush;
      r_rsp_tag   <= r_rob_tag;
      r_rsp_data  <= w_fill_word;
    end else begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign stall         = w_stall;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_tag       = r_rsp_tag;
  assign rsp_data      = r_rsp_data;
  assign mem_req_valid = w_mem_req_valid;
  assign mem_req_we    = w_mem_req_we;
  assign mem_req_addr  = r_mem_addr;
  assign mem_req_wdata = r_mem_wdata;

endmodule

// File: tb/tb_d_cache_responder.sv
// Directed self-checking bench for d_cache_responder.
module tb_d_cache_responder;
  import mips_core_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      req_valid;
  MemAccessType              req_action;
  logic [ADDR_WIDTH-1:0]     req_addr;
  logic [ROB_DEPTH_BITS-1:0] req_tag;
  logic [DATA_WIDTH-1:0]     req_data;
  logic                      flush;
  logic                      stall;
  logic                      rsp_valid;
  logic [ROB_DEPTH_BITS-1:0] rsp_tag;
  logic [DATA_WIDTH-1:0]     rsp_data;
  logic                      mem_req_valid;
  logic                      mem_req_ready;
  logic                      mem_req_we;
  logic [ADDR_WIDTH-1:0]     mem_req_addr;
  logic [DATA_WIDTH-1:0]     mem_req_wdata;
  logic                      mem_rsp_valid;
  logic [DATA_WIDTH-1:0]     mem_rsp_data;

  int n_checks = 0;
  int n_errors = 0;

  d_cache_responder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_action    (req_action),
    .req_addr      (req_addr),
    .req_tag       (req_tag),
    .req_data      (req_data),
    .flush         (flush),
    .stall         (stall),
    .rsp_valid     (rsp_valid),
    .rsp_tag       (rsp_tag),
    .rsp_data      (rsp_data),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_we    (mem_req_we),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wdata (mem_req_wdata),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // Apply one cycle of inputs at the falling edge, then settle before checking.
  task automatic drive(input logic v, input MemAccessType act, input logic [31:0] a,
                       input logic [3:0] t, input logic [31:0] d, input logic fl,
                       input logic rdy, input logic mv, input logic [31:0] md);
    @(negedge clk);
    req_valid     = v;
    req_action    = act;
    req_addr      = a;
    req_tag       = t;
    req_data      = d;
    flush         = fl;
    mem_req_ready = rdy;
    mem_rsp_valid = mv;
    mem_rsp_data  = md;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, READ, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  // Load miss: miss cycle, accepted line request, then four in-order beats.
  task automatic refill(input logic [31:0] a, input logic [3:0] t, input logic [31:0] base,
                        input logic [31:0] d0, input logic fl_beat1);
    drive(1'b1, READ, a, t, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("miss_stall", stall, 32'd1);
    chk("miss_no_memreq", mem_req_valid, 32'd0);
    drive(1'b1, READ, a, t, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("fillreq_valid", mem_req_valid, 32'd1);
    chk("fillreq_we", mem_req_we, 32'd0);
    chk("fillreq_addr", mem_req_addr, base);
    chk("fillreq_stall", stall, 32'd1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, READ, a, t, 32'h0, fl_beat1 && (i == 1), 1'b0, 1'b1, d0 + 32'(i));
      chk("fill_stall", stall, (i == 3) ? 32'd0 : 32'd1);
      chk("fill_memreq_idle", mem_req_valid, 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_action = READ; req_addr = 32'h0; req_tag = 4'h0;
    req_data = 32'h0; flush = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    mem_rsp_data = 32'h0;

    // Reset values
    @(negedge clk); #1;
    chk("rst_stall", stall, 32'd0);
    chk("rst_rsp_valid", rsp_valid, 32'd0);
    chk("rst_rsp_tag", rsp_tag, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_mem_valid", mem_req_valid, 32'd0);
    chk("rst_mem_we", mem_req_we, 32'd0);
    chk("rst_mem_addr", mem_req_addr, 32'd0);
    chk("rst_mem_wdata", mem_req_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Cold load 0x100, tag 3, line 0xA0..0xA3
    refill(32'h100, 4'd3, 32'h100, 32'hA0, 1'b0);
    idle();
    chk("cold_rsp_valid", rsp_valid, 32'd1);
    chk("cold_rsp_tag", rsp_tag, 32'd3);
    chk("cold_rsp_data", rsp_data, 32'hA0);
    chk("cold_stall_after", stall, 32'd0);
    idle();
    chk("cold_rsp_once", rsp_valid, 32'd0);

    // Hit at 0x108, tag 5
    drive(1'b1, READ, 32'h108, 4'd5, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("hit_stall", stall, 32'd0);
    idle();
    chk("hit_rsp_valid", rsp_valid, 32'd1);
    chk("hit_rsp_tag", rsp_tag, 32'd5);
    chk("hit_rsp_data", rsp_data, 32'hA2);
    idle();
    chk("hit_rsp_once", rsp_valid, 32'd0);

    // Store hit 0x104 with memory acceptance delayed three cycles
    drive(1'b1, WRITE, 32'h104, 4'd0, 32'hDEAD, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("st_stall0", stall, 32'd1);
    chk("st_no_memreq", mem_req_valid, 32'd0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, WRITE, 32'h104, 4'd0, 32'hDEAD, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("st_wait_stall", stall, 32'd1);
      chk("st_wait_valid", mem_req_valid, 32'd1);
      chk("st_wait_we", mem_req_we, 32'd1);
      chk("st_wait_addr", mem_req_addr, 32'h104);
      chk("st_wait_wdata", mem_req_wdata, 32'hDEAD);
    end
    drive(1'b1, WRITE, 32'h104, 4'd0, 32'hDEAD, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("st_ready_stall", stall, 32'd0);
    chk("st_ready_valid", mem_req_valid, 32'd1);
    chk("st_ready_addr", mem_req_addr, 32'h104);
    drive(1'b1, READ, 32'h104, 4'd7, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("st_rd_stall", stall, 32'd0);
    idle();
    chk("st_rd_valid", rsp_valid, 32'd1);
    chk("st_rd_tag", rsp_tag, 32'd7);
    chk("st_rd_data", rsp_data, 32'hDEAD);

    // Store miss 0x400 must not allocate
    drive(1'b1, WRITE, 32'h400, 4'd0, 32'h1234, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("stm_stall", stall, 32'd1);
    drive(1'b1, WRITE, 32'h400, 4'd0, 32'h1234, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("stm_we", mem_req_we, 32'd1);
    chk("stm_addr", mem_req_addr, 32'h400);
    chk("stm_wdata", mem_req_wdata, 32'h1234);
    chk("stm_stall_ready", stall, 32'd0);
    refill(32'h400, 4'd2, 32'h400, 32'hB0, 1'b0);
    idle();
    chk("stm_rd_valid", rsp_valid, 32'd1);
    chk("stm_rd_tag", rsp_tag, 32'd2);
    chk("stm_rd_data", rsp_data, 32'hB0);

    // Flush during refill of 0x200: line installed, result dropped
    refill(32'h200, 4'd9, 32'h200, 32'hC0, 1'b1);
    idle();
    chk("fl_rsp_dropped", rsp_valid, 32'd0);
    drive(1'b1, READ, 32'h20C, 4'd10, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("fl_hit_stall", stall, 32'd0);
    idle();
    chk("fl_hit_valid", rsp_valid, 32'd1);
    chk("fl_hit_tag", rsp_tag, 32'd10);
    chk("fl_hit_data", rsp_data, 32'hC3);
    // Flush coincident with a hit suppresses it
    drive(1'b1, READ, 32'h204, 4'd11, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("flhit_stall", stall, 32'd0);
    idle();
    chk("flhit_no_rsp", rsp_valid, 32'd0);

    // Reset in the middle of a refill
    drive(1'b1, READ, 32'h100, 4'd4, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("rr_miss_stall", stall, 32'd1);
    drive(1'b1, READ, 32'h100, 4'd4, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("rr_fillreq", mem_req_valid, 32'd1);
    drive(1'b1, READ, 32'h100, 4'd4, 32'h0, 1'b0, 1'b0, 1'b1, 32'hD0);
    chk("rr_beat_stall", stall, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 1'b0; mem_rsp_valid = 1'b0;
    #1;
    chk("rr_stall", stall, 32'd0);
    chk("rr_mem_valid", mem_req_valid, 32'd0);
    chk("rr_rsp_valid", rsp_valid, 32'd0);
    chk("rr_mem_addr", mem_req_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, READ, 32'h200, 4'd1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("rr_after_miss", stall, 32'd1);
    chk("rr_after_memreq", mem_req_valid, 32'd0);
    idle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/d_cache_responder.md
# d_cache_responder

Memory-side responder for the request stream driven by the memory reservation station on `d_cache_input`. It holds a small direct-mapped, write-through, no-write-allocate data cache, services loads (hit or refill) and committed stores, and returns load results with their ROB tag for the common data bus. While a request is in progress it back-pressures the issuing side through the memory-stage stall.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte address width (package constant)
- DATA_WIDTH, 32, word width (package constant)
- ROB_DEPTH_BITS, 4, ROB tag width (package constant)
- INDEX_BITS, 4, cache set index bits (16 lines)
- LINE_WORDS, 4, words per line (power of two, ≥2)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  `d_cache_input.valid`
- req_action  in  MemAccessType  READ or WRITE
- req_addr  in  ADDR_WIDTH  byte address; bits [1:0] ignored
- req_tag  in  ROB_DEPTH_BITS  ROB tag (loads only)
- req_data  in  DATA_WIDTH  store data
- flush  in  1  branch-mispredict flush
- stall  out  1  drives the memory-stage `m_hc.stall`
- rsp_valid  out  1  load result valid (to CDB)
- rsp_tag  out  ROB_DEPTH_BITS  ROB tag of result
- rsp_data  out  DATA_WIDTH  load data
- mem_req_valid  out  1  backing-memory request
- mem_req_ready  in  1  memory accepts request
- mem_req_we  out  1  1 = word write, 0 = line read
- mem_req_addr  out  ADDR_WIDTH  word address (write) or line base (read)
- mem_req_wdata  out  DATA_WIDTH  store data
- mem_rsp_valid  in  1  one refill word per asserted cycle, in order from offset 0
- mem_rsp_data  in  DATA_WIDTH  refill word

## Operation
- Address split: offset = addr[2 +: log2(LINE_WORDS)], index = next INDEX_BITS, tag = remaining upper bits. Arrays: valid bit, tag, data per line; all valid bits cleared on reset.
- The issuer holds its request registers constant while `stall`=1; the block never double-processes a held request.
- FSM states: IDLE, FILL_REQ, FILL, STORE_REQ.
- IDLE, READ hit: no stall; result registered next cycle.
- IDLE, READ miss: stall=1, latch addr/tag, go FILL_REQ.
- FILL_REQ: mem_req_valid=1, we=0, addr = line base; on mem_req_ready go FILL with beat counter=0.
- FILL: each mem_rsp_valid writes word[counter] and increments; after last beat set line valid+tag, issue result (word at requested offset), go IDLE.
- IDLE, WRITE: stall=1, go STORE_REQ; on hit, update cached word in the same edge (no allocate on miss).
- STORE_REQ: mem_req_valid=1, we=1, addr/wdata = latched values; on ready go IDLE.
- stall = (state≠IDLE) | (req_valid & (WRITE | READ miss)); deasserts in the final cycle of FILL (last beat present) and in the STORE_REQ cycle with mem_req_ready.
- flush: drops any load result pending issue (no rsp_valid for it), but a refill in progress completes and installs the line. Stores are never cancelled (ROB-committed). A flush coincident with a hit suppresses that hit's response.
- mem_req_* held stable while mem_req_valid & !mem_req_ready.

## Timing
- Reset: state IDLE; stall, rsp_valid, mem_req_valid, mem_req_we = 0; rsp_tag, rsp_data, mem_req_addr, mem_req_wdata = 0; beat counter 0.
- Load hit: request at cycle N → rsp_valid=1 for exactly one cycle at N+1.
- Load miss: ready at cycle R, last beat at cycle B → rsp_valid at B+1; stall low at B.
- Store: request at N, ready at R ≥ N+1 → stall low at R; next request accepted at R+1.
- Reset mid-refill aborts; line stays invalid.

## Structure
- MemAccessType, ADDR_WIDTH, DATA_WIDTH, ROB_DEPTH_BITS from `mips_core_pkg`; add the state enum and a `dcache_line_meta` struct (valid, tag) there.
- Sub-module `dcache_data_array` (per-word write enable, combinational read) is natural; FSM stays in the top.

## Test plan
- Cold READ 0x100, tag 3; memory returns 0xA0..0xA3 → stall through refill, rsp_tag=3, rsp_data=0xA0 one cycle after last beat.
- Then READ 0x108, tag 5 → hit, no stall, rsp_data=0xA2 next cycle.
- WRITE 0x104 data 0xDEAD with mem_req_ready delayed 3 cycles → we=1, addr=0x104 held stable, stall 4 cycles; READ 0x104 then hits with 0xDEAD.
- WRITE 0x400 (miss) then READ 0x400 → no allocation; read misses and refills.
- flush during refill of 0x200 → line installed, no rsp_valid; subsequent READ 0x200 hits.
- Assert rst_n low mid-FILL → all outputs 0 immediately; READ 0x100 afterward misses.
